// File: rtl/hrmf_pipe_if.sv
// Stream bundle for hrmf_pipe: four complex samples plus three twiddles in, four complex results out.
// Latency: none (wires only).
// Backpressure: IN_READY/OUT_READY carry the valid-ready handshake on each side.
interface hrmf_pipe_if #(
    parameter int DW = 32
);
    logic            IN_VALID;
    logic            IN_READY;
    logic            SCALE;
    logic [2*DW-1:0] D0, D1, D2, D3;
    logic [2*DW-1:0] TF1, TF2, TF3;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [2*DW-1:0] Q0, Q1, Q2, Q3;
    logic            OVF;

    modport slave (
        input  IN_VALID, SCALE, D0, D1, D2, D3, TF1, TF2, TF3, OUT_READY,
        output IN_READY, OUT_VALID, Q0, Q1, Q2, Q3, OVF
    );

    modport master (
        output IN_VALID, SCALE, D0, D1, D2, D3, TF1, TF2, TF3, OUT_READY,
        input  IN_READY, OUT_VALID, Q0, Q1, Q2, Q3, OVF
    );
endinterface

// File: rtl/hrmf_pipe.sv
// Radix-4 butterfly, then rotation of outputs 1..3 by twiddles C - jS; macro HRMF_PIPE_SAT_EN adds saturation + sticky OVF.
// Latency: 3 cycles from accept to OUT_VALID, one transaction per cycle.
// Backpressure: all stages advance together only when the output is empty or being taken; IN_READY mirrors that enable.
module hrmf_pipe #(
    parameter int DW   = 32,
    parameter int FRAC = 16
) (
    input  logic       CLK,
    input  logic       RSTn,
    hrmf_pipe_if.slave bus
);
    localparam int W = DW + 2;
    typedef logic signed [W-1:0]    wide_t;
    typedef logic signed [DW-1:0]   word_t;
    typedef logic signed [2*DW-1:0] prod_t;

    function automatic wide_t sx(input logic [DW-1:0] v);
        return {{2{v[DW-1]}}, v};
    endfunction

`ifdef HRMF_PIPE_SAT_EN
    localparam word_t S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam word_t S_MIN = {1'b1, {(DW-1){1'b0}}};

    // True when the value is representable in DW bits (top bits all copies of the sign).
    function automatic logic fits(input wide_t v);
        return (&v[W-1:DW-1]) || !(|v[W-1:DW-1]);
    endfunction
`endif

    // Reduce a DW+2 bit result to DW bits: clip when saturation is built in, wrap otherwise.
    function automatic word_t narrow(input wide_t v);
`ifdef HRMF_PIPE_SAT_EN
        if (!fits(v)) return v[W-1] ? S_MIN : S_MAX;
`endif
        return v[DW-1:0];
    endfunction

    logic v1, v2, v3;
    logic en;

    assign en           = !v3 || bus.OUT_READY;
    assign bus.IN_READY = en;
    assign bus.OUT_VALID = v3;

    // ---------------- stage 1: butterfly ----------------
    wide_t d_re [4], d_im [4];
    wide_t a_re, a_im, b_re, b_im, c_re, c_im, e_re, e_im;
    wide_t bf_re [4], bf_im [4];
    wide_t sh_re [4], sh_im [4];

    // Butterfly at DW+2 bits so no intermediate sum overflows, then optional floor divide by 4.
    always_comb begin
        d_re[0] = sx(bus.D0[2*DW-1:DW]);  d_im[0] = sx(bus.D0[DW-1:0]);
        d_re[1] = sx(bus.D1[2*DW-1:DW]);  d_im[1] = sx(bus.D1[DW-1:0]);
        d_re[2] = sx(bus.D2[2*DW-1:DW]);  d_im[2] = sx(bus.D2[DW-1:0]);
        d_re[3] = sx(bus.D3[2*DW-1:DW]);  d_im[3] = sx(bus.D3[DW-1:0]);
        a_re = d_re[0] + d_re[2];  a_im = d_im[0] + d_im[2];
        b_re = d_re[0] - d_re[2];  b_im = d_im[0] - d_im[2];
        c_re = d_re[1] + d_re[3];  c_im = d_im[1] + d_im[3];
        e_re = d_re[1] - d_re[3];  e_im = d_im[1] - d_im[3];
        // -jE = {E.im, -E.re}
        bf_re[0] = a_re + c_re;  bf_im[0] = a_im + c_im;
        bf_re[1] = b_re + e_im;  bf_im[1] = b_im - e_re;
        bf_re[2] = a_re - c_re;  bf_im[2] = a_im - c_im;
        bf_re[3] = b_re - e_im;  bf_im[3] = b_im + e_re;
        for (int k = 0; k < 4; k++) begin
            sh_re[k] = bus.SCALE ? (bf_re[k] >>> 2) : bf_re[k];
            sh_im[k] = bus.SCALE ? (bf_im[k] >>> 2) : bf_im[k];
        end
    end

    word_t x1_re [4], x1_im [4];
    word_t tc1 [3], ts1 [3];

    // Stage-1 valid: a bubble enters whenever the pipe advances without an input.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)   v1 <= 1'b0;
        else if (en) v1 <= bus.IN_VALID;
    end

    // Stage-1 data: narrowed butterfly outputs and the twiddles that belong to them.
    always_ff @(posedge CLK) begin
        if (en) begin
            for (int k = 0; k < 4; k++) begin
                x1_re[k] <= narrow(sh_re[k]);
                x1_im[k] <= narrow(sh_im[k]);
            end
            tc1[0] <= bus.TF1[2*DW-1:DW];  ts1[0] <= bus.TF1[DW-1:0];
            tc1[1] <= bus.TF2[2*DW-1:DW];  ts1[1] <= bus.TF2[DW-1:0];
            tc1[2] <= bus.TF3[2*DW-1:DW];  ts1[2] <= bus.TF3[DW-1:0];
        end
    end

    // ---------------- stage 2: products ----------------
    word_t x2_re0, x2_im0;
    logic [2:0][2*DW-1:0] p_rc, p_is, p_ic, p_rs;

    // Stage-2 valid follows stage 1 on every advance.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)   v2 <= 1'b0;
        else if (en) v2 <= v1;
    end

    // Stage-2 data: the four full-precision products per rotated lane; lane 0 just rides along.
    always_ff @(posedge CLK) begin
        if (en) begin
            x2_re0 <= x1_re[0];
            x2_im0 <= x1_im[0];
            for (int k = 0; k < 3; k++) begin
                p_rc[k] <= prod_t'(x1_re[k+1]) * prod_t'(tc1[k]);
                p_is[k] <= prod_t'(x1_im[k+1]) * prod_t'(ts1[k]);
                p_ic[k] <= prod_t'(x1_im[k+1]) * prod_t'(tc1[k]);
                p_rs[k] <= prod_t'(x1_re[k+1]) * prod_t'(ts1[k]);
            end
        end
    end

    // Only the [FRAC+DW-1:FRAC] window of each product is meaningful downstream.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{p_rc, p_is, p_ic, p_rs};

    // ---------------- stage 3: rescale and combine ----------------
    wide_t r_re [3], r_im [3];

    // (Xre + jXim)(C - jS): re = Xre*C + Xim*S, im = Xim*C - Xre*S.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            r_re[k] = sx(p_rc[k][FRAC+DW-1:FRAC]) + sx(p_is[k][FRAC+DW-1:FRAC]);
            r_im[k] = sx(p_ic[k][FRAC+DW-1:FRAC]) - sx(p_rs[k][FRAC+DW-1:FRAC]);
        end
    end

    word_t q_re [4], q_im [4];

    // Output register: loads on advance, holds while the consumer stalls.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            v3 <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                q_re[k] <= '0;
                q_im[k] <= '0;
            end
        end else if (en) begin
            v3      <= v2;
            q_re[0] <= x2_re0;
            q_im[0] <= x2_im0;
            for (int k = 0; k < 3; k++) begin
                q_re[k+1] <= narrow(r_re[k]);
                q_im[k+1] <= narrow(r_im[k]);
            end
        end
    end

    assign bus.Q0 = {q_re[0], q_im[0]};
    assign bus.Q1 = {q_re[1], q_im[1]};
    assign bus.Q2 = {q_re[2], q_im[2]};
    assign bus.Q3 = {q_re[3], q_im[3]};

`ifdef HRMF_PIPE_SAT_EN
    logic s1_hit, s3_hit, ovf_q;

    // Detect any lane that stage-1 or stage-3 narrowing had to clip.
    always_comb begin
        s1_hit = 1'b0;
        s3_hit = 1'b0;
        for (int k = 0; k < 4; k++)
            s1_hit = s1_hit | !fits(sh_re[k]) | !fits(sh_im[k]);
        for (int k = 0; k < 3; k++)
            s3_hit = s3_hit | !fits(r_re[k]) | !fits(r_im[k]);
    end

    // Sticky overflow, raised only by valid transactions that actually move this cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            ovf_q <= 1'b0;
        else if (en && ((bus.IN_VALID && s1_hit) || (v2 && s3_hit)))
            ovf_q <= 1'b1;
    end

    assign bus.OVF = ovf_q;
`else
    assign bus.OVF = 1'b0;
`endif
endmodule

// File: tb/tb_hrmf_pipe.sv
// Directed bench for hrmf_pipe: unity, twiddle rotation, scaling, backpressure, mid-flight reset, saturation.
// Latency: expects 3-cycle accept-to-output and back-to-back throughput.
// Backpressure: drives OUT_READY low for a window and checks IN_READY follows.
module tb_hrmf_pipe;
    localparam int DW   = 32;
    localparam int FRAC = 16;
    localparam logic [63:0] ONE  = {32'h00010000, 32'h00000000};
    localparam logic [63:0] ZERO = 64'h0;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    hrmf_pipe_if #(.DW(DW)) bus ();
    hrmf_pipe #(.DW(DW), .FRAC(FRAC)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [63:0] st_d  [16][4];
    logic [63:0] st_tf [16][3];
    logic        st_sc [16];
    logic [63:0] got_q [16][4];
    int          got_cyc [16];
    int          n_rcv, n_cyc, stall_cyc, stall_leak;

    // Drive up to n transactions from st_* and capture outputs; OUT_READY low for cycles [stall_at, stall_at+stall_len).
    task automatic run_stream(input int n, input int stall_at, input int stall_len);
        int sent;
        bit acc;
        sent = 0; n_rcv = 0; n_cyc = 0; stall_cyc = 0; stall_leak = 0;
        while ((sent < n || n_rcv < n) && n_cyc < 200) begin
            bus.IN_VALID = (sent < n);
            if (sent < n) begin
                bus.D0 = st_d[sent][0];  bus.D1 = st_d[sent][1];
                bus.D2 = st_d[sent][2];  bus.D3 = st_d[sent][3];
                bus.TF1 = st_tf[sent][0]; bus.TF2 = st_tf[sent][1]; bus.TF3 = st_tf[sent][2];
                bus.SCALE = st_sc[sent];
            end
            bus.OUT_READY = !(n_cyc >= stall_at && n_cyc < stall_at + stall_len);
            @(negedge CLK);
            acc = bus.IN_VALID && bus.IN_READY;
            if (bus.OUT_VALID && !bus.OUT_READY) begin
                stall_cyc++;
                if (bus.IN_READY) stall_leak++;
            end
            if (bus.OUT_VALID && bus.OUT_READY && n_rcv < 16) begin
                got_q[n_rcv][0] = bus.Q0; got_q[n_rcv][1] = bus.Q1;
                got_q[n_rcv][2] = bus.Q2; got_q[n_rcv][3] = bus.Q3;
                got_cyc[n_rcv] = n_cyc;
                n_rcv++;
            end
            @(posedge CLK); #1;
            if (acc) sent++;
            n_cyc++;
        end
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
    endtask

    // Count OUT_VALID cycles over a quiet window (used to catch stale or duplicated outputs).
    task automatic count_extra(output int cnt);
        cnt = 0;
        repeat (5) begin
            @(negedge CLK);
            if (bus.OUT_VALID) cnt++;
        end
        @(posedge CLK); #1;
    endtask

    task automatic load_unity(input int i, input logic sc);
        for (int k = 0; k < 4; k++) st_d[i][k] = ONE;
        for (int k = 0; k < 3; k++) st_tf[i][k] = ONE;
        st_sc[i] = sc;
    endtask

    task automatic load_twiddle(input int i);
        st_d[i][0] = ZERO; st_d[i][1] = ONE; st_d[i][2] = ZERO; st_d[i][3] = ZERO;
        st_tf[i][0] = {32'h00000000, 32'h00010000};
        st_tf[i][1] = ONE;
        st_tf[i][2] = ONE;
        st_sc[i] = 1'b0;
    endtask

    task automatic test_reset();
        bus.IN_VALID = 0; bus.OUT_READY = 1; bus.SCALE = 0;
        bus.D0 = 0; bus.D1 = 0; bus.D2 = 0; bus.D3 = 0;
        bus.TF1 = 0; bus.TF2 = 0; bus.TF3 = 0;
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.OUT_VALID); end
        checks++; if (bus.Q0 !== ZERO) begin errors++; $display("FAIL reset_q0 got=%h exp=%h", bus.Q0, ZERO); end
        checks++; if (bus.Q3 !== ZERO) begin errors++; $display("FAIL reset_q3 got=%h exp=%h", bus.Q3, ZERO); end
        checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.OVF); end
        RSTn = 1'b1;
        @(posedge CLK); #1;
        checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.IN_READY); end
    endtask

    task automatic test_unity();
        int extra;
        load_unity(0, 1'b0);
        run_stream(1, 999, 0);
        checks++; if (n_rcv !== 1) begin errors++; $display("FAIL unity_count got=%0d exp=1", n_rcv); end
        checks++; if (got_cyc[0] !== 3) begin errors++; $display("FAIL unity_latency got=%0d exp=3", got_cyc[0]); end
        checks++; if (got_q[0][0] !== {32'h00040000, 32'h0}) begin errors++; $display("FAIL unity_q0 got=%h exp=%h", got_q[0][0], {32'h00040000, 32'h0}); end
        for (int k = 1; k < 4; k++) begin
            checks++; if (got_q[0][k] !== ZERO) begin errors++; $display("FAIL unity_q%0d got=%h exp=%h", k, got_q[0][k], ZERO); end
        end
        count_extra(extra);
        checks++; if (extra !== 0) begin errors++; $display("FAIL unity_pulse got=%0d exp=0 extra valid cycles", extra); end
    endtask

    task automatic test_twiddle();
        logic [63:0] exp_q [4];
        exp_q[0] = {32'h00010000, 32'h0};
        exp_q[1] = {32'hFFFF0000, 32'h0};
        exp_q[2] = {32'hFFFF0000, 32'h0};
        exp_q[3] = {32'h00000000, 32'h00010000};
        load_twiddle(0);
        run_stream(1, 999, 0);
        checks++; if (n_rcv !== 1) begin errors++; $display("FAIL twiddle_count got=%0d exp=1", n_rcv); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got_q[0][k] !== exp_q[k]) begin errors++; $display("FAIL twiddle_q%0d got=%h exp=%h", k, got_q[0][k], exp_q[k]); end
        end
    endtask

    task automatic test_scale();
        logic [63:0] exp_q0 [5];
        for (int i = 0; i < 4; i++) load_unity(i, (i % 2 == 0));
        exp_q0[0] = {32'h00010000, 32'h0};
        exp_q0[1] = {32'h00040000, 32'h0};
        exp_q0[2] = {32'h00010000, 32'h0};
        exp_q0[3] = {32'h00040000, 32'h0};
        // -1 >>> 2 floors to -1; 6 >>> 2 floors to 1
        load_unity(4, 1'b1);
        st_d[4][0] = {32'hFFFFFFFF, 32'h00000006};
        st_d[4][1] = ZERO; st_d[4][2] = ZERO; st_d[4][3] = ZERO;
        exp_q0[4] = {32'hFFFFFFFF, 32'h00000001};
        run_stream(5, 999, 0);
        checks++; if (n_rcv !== 5) begin errors++; $display("FAIL scale_count got=%0d exp=5", n_rcv); end
        checks++; if (n_cyc !== 8) begin errors++; $display("FAIL scale_cycles got=%0d exp=8", n_cyc); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got_q[i][0] !== exp_q0[i]) begin errors++; $display("FAIL scale_q0[%0d] got=%h exp=%h", i, got_q[i][0], exp_q0[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_v [8];
        int extra;
        for (int i = 0; i < 8; i++) begin
            exp_v[i] = {32'(i + 1) << 16, 32'(i + 3) << 16};
            st_d[i][0] = exp_v[i];
            st_d[i][1] = ZERO; st_d[i][2] = ZERO; st_d[i][3] = ZERO;
            for (int k = 0; k < 3; k++) st_tf[i][k] = ONE;
            st_sc[i] = 1'b0;
        end
        run_stream(8, 5, 5);
        checks++; if (n_rcv !== 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", n_rcv); end
        checks++; if (stall_cyc !== 5) begin errors++; $display("FAIL b2b_stall_cycles got=%0d exp=5", stall_cyc); end
        checks++; if (stall_leak !== 0) begin errors++; $display("FAIL b2b_in_ready_in_stall got=%0d exp=0", stall_leak); end
        checks++; if (n_cyc !== 16) begin errors++; $display("FAIL b2b_cycles got=%0d exp=16", n_cyc); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (got_q[i][0] !== exp_v[i]) begin errors++; $display("FAIL b2b_q0[%0d] got=%h exp=%h", i, got_q[i][0], exp_v[i]); end
            checks++; if (got_q[i][3] !== exp_v[i]) begin errors++; $display("FAIL b2b_q3[%0d] got=%h exp=%h", i, got_q[i][3], exp_v[i]); end
        end
        count_extra(extra);
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_duplicates got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_midflight();
        int extra;
        bus.D0 = ONE; bus.D1 = ONE; bus.D2 = ONE; bus.D3 = ONE;
        bus.TF1 = ONE; bus.TF2 = ONE; bus.TF3 = ONE; bus.SCALE = 1'b0;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL midrst_full got=%b exp=1", bus.OUT_VALID); end
        bus.IN_VALID = 1'b0;
        RSTn = 1'b0;
        #1;
        checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL midrst_async got=%b exp=0", bus.OUT_VALID); end
        @(posedge CLK); #1;
        RSTn = 1'b1;
        count_extra(extra);
        checks++; if (extra !== 0) begin errors++; $display("FAIL midrst_stale got=%0d exp=0", extra); end
        load_twiddle(0);
        run_stream(1, 999, 0);
        checks++; if (got_cyc[0] !== 3) begin errors++; $display("FAIL midrst_latency got=%0d exp=3", got_cyc[0]); end
        checks++; if (got_q[0][1] !== {32'hFFFF0000, 32'h0}) begin errors++; $display("FAIL midrst_q1 got=%h exp=%h", got_q[0][1], {32'hFFFF0000, 32'h0}); end
    endtask

    task automatic test_saturation();
        logic [63:0] exp_q0;
        logic        exp_ovf;
`ifdef HRMF_PIPE_SAT_EN
        exp_q0  = {32'h7FFFFFFF, 32'h0};
        exp_ovf = 1'b1;
`else
        exp_q0  = {32'hFFFC0000, 32'h0};
        exp_ovf = 1'b0;
`endif
        checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL sat_ovf_before got=%b exp=0", bus.OVF); end
        load_unity(0, 1'b0);
        for (int k = 0; k < 4; k++) st_d[0][k] = {32'h7FFF0000, 32'h0};
        run_stream(1, 999, 0);
        checks++; if (got_q[0][0] !== exp_q0) begin errors++; $display("FAIL sat_q0 got=%h exp=%h", got_q[0][0], exp_q0); end
        checks++; if (bus.OVF !== exp_ovf) begin errors++; $display("FAIL sat_ovf got=%b exp=%b", bus.OVF, exp_ovf); end
        load_unity(0, 1'b0);
        run_stream(1, 999, 0);
        checks++; if (got_q[0][0] !== {32'h00040000, 32'h0}) begin errors++; $display("FAIL sat_recover_q0 got=%h exp=%h", got_q[0][0], {32'h00040000, 32'h0}); end
        checks++; if (bus.OVF !== exp_ovf) begin errors++; $display("FAIL sat_ovf_sticky got=%b exp=%b", bus.OVF, exp_ovf); end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_twiddle();
        test_scale();
        test_back_to_back();
        test_reset_midflight();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
